// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default bus widths and the fetch FSM state encoding.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_REQ     = 2'b00,
    S_WAIT    = 2'b01,
    S_HOLD    = 2'b10,
    S_DISCARD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: async active-low reset to a supplied value, redirect load, wrapping increment.
module pc_reg #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rst_val,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // Load outranks increment; the add wraps naturally at ADDR_W bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= rst_val;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, runs the memory req/gnt/rvalid handshake and presents
// the fetched word to the decoder with valid/ready; redirects flush any stale in-flight fetch.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        state_out
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              capture;

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .rst_val (RESET_PC),
    .load    (redirect),
    .inc     (pc_inc),
    .target  (redirect_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect wins everywhere; an accepted-but-unanswered request must drain through DISCARD.
  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect) begin
          state_nxt = mem_gnt ? S_DISCARD : S_REQ;
        end else if (mem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = mem_rvalid ? S_REQ : S_DISCARD;
        end else if (mem_rvalid) begin
          capture   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || instr_ready) begin
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        if (mem_rvalid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_out <= '0;
      instr_pc  <= '0;
    end else if (capture) begin
      instr_out <= mem_rdata;
      instr_pc  <= pc;
    end
  end

  assign mem_req     = (state == S_REQ);
  assign mem_addr    = pc;
  assign instr_valid = (state == S_HOLD);
  assign state_out   = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: bench-driven memory responder with a scoreboard of expected (pc, word) pairs.
module tb_inst_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [1:0]        state_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W+DATA_W-1:0] sb_q[$];

  inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop_check();
    logic [ADDR_W+DATA_W-1:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("instr_out", 32'(instr_out), 32'(e[DATA_W-1:0]));
      chk("instr_pc", 32'(instr_pc), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
    end
  endtask

  // Called at a negedge with the DUT in REQ; returns at the negedge where HOLD is visible.
  task automatic fetch_to_hold(input logic [DATA_W-1:0] data);
    chk("req_state", 32'(state_out), 32'd0);
    chk("req_mem_req", 32'(mem_req), 32'd1);
    chk("req_addr", 32'(mem_addr), 32'(m_pc));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait_state", 32'(state_out), 32'd1);
    chk("wait_mem_req", 32'(mem_req), 32'd0);
    sb_q.push_back({m_pc, data});
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    m_pc = m_pc + 8'd1;
    chk("hold_valid", 32'(instr_valid), 32'd1);
    sb_pop_check();
    chk("hold_next_addr", 32'(mem_addr), 32'(m_pc));
  endtask

  task automatic fetch(input logic [DATA_W-1:0] data, input int stall);
    fetch_to_hold(data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_instr_stable", 32'(instr_out), 32'(data));
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_mem_req", 32'(mem_req), 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("consumed_mem_req", 32'(mem_req), 32'd1);
    chk("consumed_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    m_pc = 8'h00;
    @(negedge clk);
    reset = 1'b1;

    // zero-wait first fetch, then one under 5 cycles of backpressure
    fetch(16'hD105, 0);
    fetch(16'h1234, 5);

    // grant stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_state", 32'(state_out), 32'd0);
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'(m_pc));
    end
    fetch(16'hA5A5, 1);

    // redirect in WAIT; stale word returns two cycles later
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw_wait", 32'(state_out), 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    m_pc = 8'h40;
    chk("rw_discard", 32'(state_out), 32'd3);
    chk("rw_no_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("rw_discard2", 32'(state_out), 32'd3);
    mem_rvalid = 1'b1;
    mem_rdata = 16'hBAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rw_back_req", 32'(state_out), 32'd0);
    chk("rw_no_stale", 32'(instr_valid), 32'd0);
    chk("rw_addr", 32'(mem_addr), 32'h40);
    fetch(16'h4040, 0);

    // redirect together with gnt in REQ
    mem_gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h80;
    @(negedge clk);
    mem_gnt = 1'b0;
    redirect = 1'b0;
    m_pc = 8'h80;
    chk("rg_discard", 32'(state_out), 32'd3);
    chk("rg_addr", 32'(mem_addr), 32'h80);
    mem_rvalid = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rg_req", 32'(state_out), 32'd0);
    chk("rg_no_valid", 32'(instr_valid), 32'd0);

    // redirect plus ready in HOLD, then wrap at 0xFF
    fetch_to_hold(16'h7777);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect = 1'b0;
    m_pc = 8'hFF;
    chk("rh_state", 32'(state_out), 32'd0);
    chk("rh_no_valid", 32'(instr_valid), 32'd0);
    chk("rh_addr", 32'(mem_addr), 32'hFF);
    fetch(16'hFFFF, 0);
    chk("wrap_addr", 32'(mem_addr), 32'h00);

    // asynchronous reset pulse mid-WAIT, between clock edges
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("ar_wait", 32'(state_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_state", 32'(state_out), 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_instr", 32'(instr_out), 32'd0);
    chk("ar_ipc", 32'(instr_pc), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'd0);
    #1 reset = 1'b1;
    m_pc = 8'h00;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 16'hCAFE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rv_state", 32'(state_out), 32'd0);
    chk("late_rv_valid", 32'(instr_valid), 32'd0);
    chk("late_rv_addr", 32'(mem_addr), 32'd0);
    fetch(16'h0101, 0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder and CPU controller FSM. Owns the program counter, issues read requests to instruction memory over a request/grant/response handshake, and captures the returned word into the instruction register. Presents the instruction to the decoder with a valid/ready handshake. Accepts branch redirects from the controller and discards any in-flight stale fetch.

## Interface
- ADDR_W, 8, instruction memory word-address width
- DATA_W, 16, instruction width (matches decoder input)
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk)
- mem_req  output  1  fetch request, high in REQ state
- mem_addr  output  ADDR_W  fetch address (= pc)
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  mem_rdata valid this cycle; at least 1 cycle after the matching gnt
- mem_rdata  input  DATA_W  returned instruction word
- instr_out  output  DATA_W  instruction register contents, to decoder
- instr_valid  output  1  instr_out holds an unconsumed instruction
- instr_ready  input  1  decoder/controller consumes instr_out this cycle
- instr_pc  output  ADDR_W  address instr_out was fetched from
- redirect  input  1  load new PC, flush fetch
- redirect_pc  input  ADDR_W  redirect target
- state_out  output  2  current FSM state, for LED debug

## Operation
- States: REQ=2'b00, WAIT=2'b01, HOLD=2'b10, DISCARD=2'b11.
- Reset values: state=REQ, pc=RESET_PC, instr_out=0, instr_valid=0, instr_pc=0.
- mem_req = (state==REQ); mem_addr = pc; instr_valid = (state==HOLD). All combinational from registered state/pc.
- REQ: gnt -> WAIT. No gnt -> stay.
- WAIT: rvalid -> instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+1, -> HOLD.
- HOLD: instr_ready -> REQ. Otherwise hold instr_out/instr_pc stable.
- DISCARD: rvalid -> drop data, -> REQ.
- Redirect has priority over every other event. pc<=redirect_pc in all states, then:
  - REQ, no gnt: stay REQ.
  - REQ with gnt: -> DISCARD, because the accepted request is stale.
  - WAIT with rvalid: drop data, -> REQ.
  - WAIT without rvalid: -> DISCARD.
  - HOLD: -> REQ; instruction dropped even if instr_ready was high.
  - DISCARD: stay DISCARD until rvalid.
- pc+1 wraps modulo 2^ADDR_W (all-ones -> 0). No overflow flag.
- mem_rvalid in REQ or HOLD is ignored. Memory protocol guarantees this never occurs.

## Timing
- Zero-wait memory: gnt in cycle N, rvalid in N+1, instr_valid high from N+2.
- Back-to-back throughput: ready in cycle M gives mem_req in M+1. Steady state is 1 instruction per 3 cycles.
- Redirect in cycle N: mem_addr=redirect_pc from N+1 (or after DISCARD drains).
- Reset assertion mid-fetch: outputs reset immediately. Any later rvalid lands in REQ and is ignored.

## Structure
- Shared package `fetch_pkg` holds:
  - state encoding localparams (REQ/WAIT/HOLD/DISCARD)
  - the default ADDR_W/DATA_W constants, also used by the datapath and decoder
- One natural sub-module, `pc_reg`:
  - inputs: reset value, load (redirect), increment, target
  - provides: async active-low reset, wrapping increment
- FSM and instruction register stay in `inst_fetch`.

## Test plan
- Reset to RESET_PC=0: release reset, gnt immediately, rvalid next cycle with 16'hD105 -> instr_valid=1, instr_out=16'hD105, instr_pc=0, mem_addr=1.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr_out stable, mem_req=0. Then ready=1 -> mem_req=1 next cycle.
- Grant stall: withhold gnt 3 cycles -> mem_req and mem_addr stay constant, state_out=00.
- Redirect in WAIT, rvalid 2 cycles later, redirect_pc=8'h40 -> state_out=11, returned word dropped, then mem_addr=8'h40, no instr_valid for the stale word.
- Redirect and instr_ready together in HOLD -> next mem_addr=redirect_pc, instruction not re-presented. Fetch at pc=8'hFF -> pc wraps to 8'h00.
- Async reset pulse mid-WAIT, with no clk edge -> outputs zero immediately. A late rvalid after release is ignored.
